leaf_out_packetizer: RTL and testbench
======================================

Name: leaf_out_packetizer

Overview:
- Transmit-side packetizer of a leaf. Accepts 32-bit user output streams on valid/ack ports, arbitrates round-robin among them and emits one 49-bit BFT packet per cycle toward the network.
- Enforces per-port credit flow control against the destination leaf's receive BRAM; credit returns arrive as freespace updates.
- Counterpart of the leaf receive/depacketize path.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, write-address field width.
- NUM_OUT_PORTS, 7, number of user output streams (max 2^NUM_PORT_BITS-1).
- NUM_BRAM_ADDR_BITS, 7, receiver buffer depth exponent; initial credit = 2^NUM_BRAM_ADDR_BITS.
- FREESPACE_UPDATE_SIZE, 64, credits restored per credit-return event.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  per-port payloads; port i at bits [i*32 +: 32].
- vld_user2interface  in  NUM_OUT_PORTS  per-port valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept (one-hot or zero).
- cfg_wr  in  1  config write strobe.
- cfg_port  in  NUM_PORT_BITS  local output port index being configured (0-based).
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_dest_port  in  NUM_PORT_BITS  destination port on that leaf.
- credit_vld  in  1  freespace update strobe.
- credit_port  in  NUM_PORT_BITS  local port receiving the update.
- resend  in  1  network back-pressure/replay; blocks new grants.
- dout_leaf_interface2bft  out  PACKET_BITS  packet to BFT.
- credit_err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (reset_n=0, async):
  - dout=0, ack=0, credit_err=0.
  - All ports unconfigured.
  - Credit counters = 2^NUM_BRAM_ADDR_BITS (128).
  - Address pointers = 0.
  - RR pointer = 0.
- Packet format:
  - [48] valid=1.
  - [47:43] dest leaf.
  - [42:39] dest port.
  - [38:32] per-port write address.
  - [31:0] payload.
  - Idle cycle emits all-zero.
- Eligibility of port i: vld[i] & configured[i] & credit[i]!=0 & !resend.
- Arbitration:
  - Round-robin, combinational; search starts at rr_ptr.
  - ack[i]=1 in the same cycle for exactly the winning port; transfer occurs on vld&ack.
  - rr_ptr <= winner+1, wrapping at NUM_OUT_PORTS-1 -> 0.
  - rr_ptr is unchanged when there is no grant.
- Latency: packet appears on dout on the clock edge following acceptance (1 cycle, registered).
- On grant of port i:
  - credit[i] decrements by 1.
  - addr[i] increments modulo 2^NUM_ADDR_BITS (127 -> 0).
- resend=1:
  - No acks are issued.
  - dout is driven 0 from the next edge.
  - Counters are held.
- Config:
  - cfg_wr latches dest leaf/port for cfg_port and sets configured.
  - Resets that port's addr to 0 and its credit to 128.
  - cfg_port >= NUM_OUT_PORTS is ignored.
  - A config write and a grant on the same port in the same cycle: the grant uses the old dest, then config wins for all state.
- Credit return:
  - credit_vld adds FREESPACE_UPDATE_SIZE to credit[credit_port].
  - Simultaneous grant on the same port gives a net change of +63.
  - Result > 128: clamp to 128 and set credit_err, which stays set until reset.
  - Out-of-range credit_port is ignored.
- Counter width: NUM_BRAM_ADDR_BITS+1 bits (0..128).
- Zero credit: the port is skipped by the arbiter; its vld is held without ack. Other ports proceed.
- Reset mid-operation: all state clears immediately; an in-flight output packet is dropped (dout=0).

Test Plan:
- Configure port0 -> leaf 3/port 2, drive vld[0] with payload 0xDEADBEEF -> ack[0] same cycle; next cycle dout = {1,5'd3,4'd2,7'd0,32'hDEADBEEF}; second word carries addr 1.
- Ports 0, 2 and 5 configured and continuously valid -> grant order 0,2,5,0,2,5…; each port has 1 packet per 3 cycles.
- Single port streams 128 words with no credits -> acks stop after 128 words with addr wrapping 127 -> 0. One credit_vld then releases exactly 64 more.
- credit_vld on a port at 100 credits -> clamps at 128 and credit_err=1; it remains 1 through further traffic until reset_n pulses low.
- resend=1 for 5 cycles while all ports are valid -> no acks and dout=0. After deassertion, arbitration resumes from the preserved rr_ptr.
- Unconfigured port 6 is valid -> never acked. reset_n is asserted while streaming -> dout=0 and ack=0 asynchronously; after release, credits are 128 and addresses are 0.

Source files
------------

// File: rtl/leaf_out_packetizer.sv
// Leaf transmit packetizer: round-robin over user output streams, per-port
// destination/address/credit state, one registered BFT packet per cycle.

module leaf_out_port_state #(
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          grant,
  input  logic                          cfg_hit,
  input  logic [NUM_LEAF_BITS-1:0]      cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]      cfg_dport,
  input  logic                          credit_hit,
  output logic                          configured,
  output logic [NUM_LEAF_BITS-1:0]      dest_leaf,
  output logic [NUM_PORT_BITS-1:0]      dest_port,
  output logic [NUM_ADDR_BITS-1:0]      addr,
  output logic [NUM_BRAM_ADDR_BITS:0]   credit,
  output logic                          ovf
);
  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CW:0] CMAX = (CW+1)'(1 << NUM_BRAM_ADDR_BITS);
  localparam logic [CW:0] FSU  = (CW+1)'(FREESPACE_UPDATE_SIZE);

  logic                     cfgd_q, cfgd_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
  logic [NUM_PORT_BITS-1:0] dport_q, dport_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CW-1:0]            credit_q, credit_d;
  logic [CW:0]              sum;

  // One extra bit on the sum so a return on top of a nearly full counter is visible.
  always_comb begin
    cfgd_d   = cfgd_q;
    leaf_d   = leaf_q;
    dport_d  = dport_q;
    addr_d   = addr_q + {{(NUM_ADDR_BITS-1){1'b0}}, grant};
    ovf      = 1'b0;
    sum      = {1'b0, credit_q} - (CW+1)'(grant) + (credit_hit ? FSU : '0);
    credit_d = sum[CW-1:0];
    if (sum > CMAX) begin
      credit_d = CMAX[CW-1:0];
      ovf      = 1'b1;
    end
    if (cfg_hit) begin
      cfgd_d   = 1'b1;
      leaf_d   = cfg_leaf;
      dport_d  = cfg_dport;
      addr_d   = '0;
      credit_d = CMAX[CW-1:0];
      ovf      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfgd_q   <= 1'b0;
      leaf_q   <= '0;
      dport_q  <= '0;
      addr_q   <= '0;
      credit_q <= CMAX[CW-1:0];
    end else begin
      cfgd_q   <= cfgd_d;
      leaf_q   <= leaf_d;
      dport_q  <= dport_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
    end
  end

  assign configured = cfgd_q;
  assign dest_leaf  = leaf_q;
  assign dest_port  = dport_q;
  assign addr       = addr_q;
  assign credit     = credit_q;
endmodule

module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  output logic                                  credit_err
);
  localparam int NP = NUM_OUT_PORTS;
  localparam int IW = NUM_PORT_BITS;

  logic [NP-1:0]                         configured, elig, ack_vec, cfg_hit, credit_hit, ovf;
  logic [NP-1:0][NUM_LEAF_BITS-1:0]      dest_leaf;
  logic [NP-1:0][NUM_PORT_BITS-1:0]      dest_port;
  logic [NP-1:0][NUM_ADDR_BITS-1:0]      addr;
  logic [NP-1:0][NUM_BRAM_ADDR_BITS:0]   credit;

  logic [IW-1:0]          rr_ptr_q, rr_ptr_d, hi_idx, lo_idx, win_idx;
  logic                   hi_found, lo_found;
  logic [PACKET_BITS-1:0] dout_q, dout_d;
  logic                   err_q, err_d;

  // Out-of-range cfg/credit port indices simply match no lane.
  for (genvar i = 0; i < NP; i++) begin : g_port
    assign cfg_hit[i]    = cfg_wr && (cfg_port == IW'(i));
    assign credit_hit[i] = credit_vld && (credit_port == IW'(i));
    assign elig[i]       = vld_user2interface[i] && configured[i] && (credit[i] != '0) && !resend;

    leaf_out_port_state #(
      .NUM_LEAF_BITS        (NUM_LEAF_BITS),
      .NUM_PORT_BITS        (NUM_PORT_BITS),
      .NUM_ADDR_BITS        (NUM_ADDR_BITS),
      .NUM_BRAM_ADDR_BITS   (NUM_BRAM_ADDR_BITS),
      .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
    ) u_port (
      .clk       (clk),
      .reset_n   (reset_n),
      .grant     (ack_vec[i]),
      .cfg_hit   (cfg_hit[i]),
      .cfg_leaf  (cfg_dest_leaf),
      .cfg_dport (cfg_dest_port),
      .credit_hit(credit_hit[i]),
      .configured(configured[i]),
      .dest_leaf (dest_leaf[i]),
      .dest_port (dest_port[i]),
      .addr      (addr[i]),
      .credit    (credit[i]),
      .ovf       (ovf[i])
    );
  end

  // Lowest eligible index at/after rr_ptr wins; otherwise wrap to lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
        if (IW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    ack_vec = '0;
    for (int i = 0; i < NP; i++)
      if (lo_found && win_idx == IW'(i)) ack_vec[i] = 1'b1;
  end

  always_comb begin
    dout_d = '0;
    for (int i = 0; i < NP; i++)
      if (ack_vec[i])
        dout_d = PACKET_BITS'({1'b1, dest_leaf[i], dest_port[i], addr[i],
                               din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]});
    rr_ptr_d = rr_ptr_q;
    if (lo_found) rr_ptr_d = (win_idx == IW'(NP - 1)) ? '0 : win_idx + 1'b1;
    err_d = err_q | (|ovf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q   <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign ack_interface2user      = ack_vec;
  assign dout_leaf_interface2bft = dout_q;
  assign credit_err              = err_q;
endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Bench for leaf_out_packetizer: directed table, corner sequences and random
// traffic against a queue/array-level model of the packet/credit rules.

module tb_leaf_out_packetizer;
  localparam int N = 7;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N*32-1:0] din;
  logic [N-1:0]  vld;
  logic [N-1:0]  ack;
  logic          cfg_wr;
  logic [3:0]    cfg_port;
  logic [4:0]    cfg_dest_leaf;
  logic [3:0]    cfg_dest_port;
  logic          credit_vld;
  logic [3:0]    credit_port;
  logic          resend;
  logic [48:0]   dout;
  logic          credit_err;

  always #5 clk = ~clk;

  leaf_out_packetizer dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .din_leaf_user2interface(din),
    .vld_user2interface     (vld),
    .ack_interface2user     (ack),
    .cfg_wr                 (cfg_wr),
    .cfg_port               (cfg_port),
    .cfg_dest_leaf          (cfg_dest_leaf),
    .cfg_dest_port          (cfg_dest_port),
    .credit_vld             (credit_vld),
    .credit_port            (credit_port),
    .resend                 (resend),
    .dout_leaf_interface2bft(dout),
    .credit_err             (credit_err)
  );

  int checks = 0;
  int errors = 0;

  bit         m_cfg[N];
  logic [4:0] m_leaf[N];
  logic [3:0] m_dport[N];
  int         m_addr[N];
  int         m_cred[N];
  int         m_rr;
  bit         m_err;
  logic [N-1:0] last_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int p = 0; p < N; p++) begin
      m_cfg[p] = 0; m_leaf[p] = '0; m_dport[p] = '0; m_addr[p] = 0; m_cred[p] = 128;
    end
    m_rr = 0; m_err = 0;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_rr + k) % N;
      if (vld[p] && m_cfg[p] && m_cred[p] > 0 && !resend) return p;
    end
    return -1;
  endfunction

  task automatic m_update(input int w);
    for (int p = 0; p < N; p++) begin
      if (cfg_wr && int'(cfg_port) == p) begin
        m_cfg[p] = 1; m_leaf[p] = cfg_dest_leaf; m_dport[p] = cfg_dest_port;
        m_addr[p] = 0; m_cred[p] = 128;
      end else begin
        if (p == w) begin
          m_cred[p]--;
          m_addr[p] = (m_addr[p] + 1) % 128;
        end
        if (credit_vld && int'(credit_port) == p) begin
          m_cred[p] += 64;
          if (m_cred[p] > 128) begin m_cred[p] = 128; m_err = 1; end
        end
      end
    end
    if (w >= 0) m_rr = (w + 1) % N;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step(input string tag);
    int w;
    logic [48:0] pkt;
    logic [N-1:0] ea;
    #1;
    w = pick();
    ea = '0;
    pkt = '0;
    if (w >= 0) begin
      ea[w] = 1'b1;
      pkt = {1'b1, m_leaf[w], m_dport[w], 7'(m_addr[w]), din[w*32 +: 32]};
    end
    chk({tag, " ack"}, 64'(ack), 64'(ea));
    last_ack = ack;
    m_update(w);
    @(posedge clk);
    #1;
    chk({tag, " dout"}, 64'(dout), 64'(pkt));
    chk({tag, " err"}, 64'(credit_err), 64'(m_err));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vld = '0; cfg_wr = 0; cfg_port = '0; cfg_dest_leaf = '0; cfg_dest_port = '0;
    credit_vld = 0; credit_port = '0; resend = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 0;
    #1;
    chk({tag, " rst ack"}, 64'(ack), 64'd0);
    chk({tag, " rst dout"}, 64'(dout), 64'd0);
    chk({tag, " rst err"}, 64'(credit_err), 64'd0);
    m_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic cfg(input int p, input int leaf, input int dp);
    vld = '0;
    cfg_wr = 1; cfg_port = 4'(p); cfg_dest_leaf = 5'(leaf); cfg_dest_port = 4'(dp);
    step("cfg");
    cfg_wr = 0;
  endtask

  typedef struct {
    logic        cw;
    logic [3:0]  cp;
    logic [4:0]  cl;
    logic [3:0]  cd;
    logic        v0;
    logic [31:0] d0;
    logic [6:0]  eack;
    logic [48:0] edout;
  } vec_t;

  vec_t tbl[7];
  int   cnt;
  int   order[3];

  initial begin
    tbl[0] = '{1'b1, 4'd0, 5'd3, 4'd2, 1'b0, 32'h0,        7'd0, 49'd0};
    tbl[1] = '{1'b0, 4'd0, 5'd0, 4'd0, 1'b1, 32'hDEADBEEF, 7'd1, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}};
    tbl[2] = '{1'b0, 4'd0, 5'd0, 4'd0, 1'b1, 32'h12345678, 7'd1, {1'b1, 5'd3, 4'd2, 7'd1, 32'h12345678}};
    tbl[3] = '{1'b1, 4'd7, 5'd9, 4'd9, 1'b0, 32'h0,        7'd0, 49'd0};
    tbl[4] = '{1'b0, 4'd0, 5'd0, 4'd0, 1'b1, 32'hCAFEF00D, 7'd1, {1'b1, 5'd3, 4'd2, 7'd2, 32'hCAFEF00D}};
    tbl[5] = '{1'b1, 4'd0, 5'd5, 4'd1, 1'b1, 32'h0BADCAFE, 7'd1, {1'b1, 5'd3, 4'd2, 7'd3, 32'h0BADCAFE}};
    tbl[6] = '{1'b0, 4'd0, 5'd0, 4'd0, 1'b1, 32'h55AA55AA, 7'd1, {1'b1, 5'd5, 4'd1, 7'd0, 32'h55AA55AA}};

    idle_inputs();
    din = '0;
    reset_n = 0;
    m_reset();
    #1;
    chk("por ack", 64'(ack), 64'd0);
    chk("por dout", 64'(dout), 64'd0);
    chk("por err", 64'(credit_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    // Directed table: basic packet, address increment, ignored config, config/grant collision
    for (int i = 0; i < 7; i++) begin
      cfg_wr = tbl[i].cw; cfg_port = tbl[i].cp; cfg_dest_leaf = tbl[i].cl; cfg_dest_port = tbl[i].cd;
      vld = {6'b0, tbl[i].v0}; din[31:0] = tbl[i].d0;
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d exp ack", i), 64'(last_ack), 64'(tbl[i].eack));
      chk($sformatf("tbl%0d exp dout", i), 64'(dout), 64'(tbl[i].edout));
    end
    idle_inputs();

    // Round robin among ports 0, 2, 5
    do_reset("rr");
    cfg(0, 1, 1); cfg(2, 2, 2); cfg(5, 4, 3);
    order[0] = 0; order[1] = 2; order[2] = 5;
    vld = 7'b0100101;
    for (int k = 0; k < 9; k++) begin
      for (int p = 0; p < N; p++) din[p*32 +: 32] = $urandom;
      step("rr");
      chk("rr order", 64'(last_ack), 64'(7'(1 << order[k % 3])));
    end
    idle_inputs();

    // Credit exhaustion, address wrap, then one return releases 64
    do_reset("cred");
    cfg(1, 9, 4);
    vld = 7'b0000010;
    cnt = 0;
    for (int k = 0; k < 135; k++) begin
      din[63:32] = k;
      step("cred");
      if (last_ack[1]) cnt++;
    end
    chk("cred 128 acks", 64'(cnt), 64'd128);
    vld = '0; credit_vld = 1; credit_port = 4'd1;
    step("cred ret");
    credit_vld = 0;
    vld = 7'b0000010;
    cnt = 0;
    for (int k = 0; k < 70; k++) begin
      step("cred2");
      if (last_ack[1]) cnt++;
    end
    chk("cred 64 acks", 64'(cnt), 64'd64);
    idle_inputs();

    // Overflow clamp and sticky error
    do_reset("ovf");
    cfg(3, 2, 6);
    vld = 7'b0001000;
    for (int k = 0; k < 28; k++) step("ovf fill");
    vld = '0; credit_vld = 1; credit_port = 4'd3;
    step("ovf ret");
    credit_vld = 0;
    chk("ovf err set", 64'(credit_err), 64'd1);
    vld = 7'b0001000;
    for (int k = 0; k < 10; k++) step("ovf more");
    chk("ovf err sticky", 64'(credit_err), 64'd1);
    idle_inputs();
    do_reset("ovf clr");
    chk("ovf err cleared", 64'(credit_err), 64'd0);

    // Resend blocks grants; rr pointer is preserved; port 6 is never configured
    for (int p = 0; p < 6; p++) cfg(p, p + 10, p);
    vld = 7'h7F;
    for (int k = 0; k < 3; k++) step("pre rs");
    resend = 1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step("rs");
      if (last_ack != 0) cnt++;
    end
    chk("rs no acks", 64'(cnt), 64'd0);
    chk("rs dout zero", 64'(dout), 64'd0);
    resend = 0;
    step("rs resume");
    chk("rs resume port3", 64'(last_ack), 64'h8);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step("p6");
      if (last_ack[6]) cnt++;
    end
    chk("p6 never acked", 64'(cnt), 64'd0);

    // Async reset while streaming, then fresh address after reconfig
    do_reset("mid");
    vld = '0;
    cfg(0, 3, 2);
    vld = 7'b0000001;
    step("mid post");
    chk("mid addr0", 64'(dout[38:32]), 64'd0);
    idle_inputs();

    // Random traffic against the model
    do_reset("rnd");
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < N; p++) din[p*32 +: 32] = $urandom;
      vld = 7'($urandom);
      cfg_wr = ($urandom % 16) == 0;
      cfg_port = 4'($urandom % 8);
      cfg_dest_leaf = 5'($urandom);
      cfg_dest_port = 4'($urandom);
      credit_vld = ($urandom % 8) == 0;
      credit_port = 4'($urandom);
      resend = ($urandom % 10) == 0;
      step("rnd");
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
